seven_seg_capture: RTL and testbench
====================================

# seven_seg_capture

Capture and readback block for the multiplexed 4-digit 7-segment display bus: digit enables on io 7–10 and segments a–g plus dp on io 11–18. It samples the scanned digit/segment lines and filters out transitions. It reconstructs each digit as a hex value and exposes the current display image, frame count and error flags to the management SoC over Wishbone. It sits beside the display driver inside user_project_wrapper, looping the pad outputs back in for self-test and on-chip display verification.

## Interface
- BASE_ADR, 32'h3000_0000, Wishbone window base; decode compares adr[31:4].
- STABLE_CYCLES, 4, consecutive identical samples required before capture (≥2).
- CNT_W, 16, frame counter width (≤16).

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1  Wishbone classic strobes.
- wbs_sel_i  in  4  byte selects; honoured on CTRL writes only.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_dat_o  out  32  read data.
- digit_en_i  in  4  digit enables, active-high, one-hot when displaying.
- seg_i  in  8  [6:0] segments a..g, [7] dp, active-high.
- irq_o  out  1  frame-complete pulse.

## Operation
- digit_en_i/seg_i pass through a 2-flop synchronizer.
- Filter: the synchronized 12-bit sample is compared with the previous one. A change resets the stability counter and re-arms capture. When the counter reaches STABLE_CYCLES-1 while armed, one capture occurs and the filter disarms.
- Capture by enable pattern:
  - Zero: blanking; nothing happens.
  - Non-one-hot: sets sticky onehot_err; no capture.
  - One-hot index k: writes raw[k]=seg, dp[k]=seg[7], and hex[k]/valid[k] from decode.
- Decode: the standard hex glyph set 0–F (b and d lowercase). Any other pattern gives valid=0, hex=0.
- Frame sequencer, state EXP ∈ {0,1,2,3}, reset 0:
  - Capture of k==EXP advances EXP. Capture of 3 in EXP=3 increments frame_cnt (wraps to 0), sets sticky frame_done, pulses irq_o if irq_en, and returns EXP to 0.
  - Capture of k≠EXP sets sticky seq_err. EXP becomes 1 if k==0, else 0.
- Registers (offset = adr[3:2]):
  - 0x0 DIGITS (RO): [15:0] hex d3..d0 (d0 in [3:0]), [19:16] valid, [23:20] dp.
  - 0x4 RAW (RO): seg byte per digit, d0 in [7:0].
  - 0x8 STATUS (RO): [CNT_W-1:0] frame_cnt, [16] seq_err, [17] onehot_err, [18] frame_done.
  - 0xC CTRL: [0] irq_en (R/W, sel[0]). Writing [1]=1 clears frame_cnt, the sticky flags and EXP; reads 0.
- Writes to RO registers are acked and ignored. Unused bits read 0.
- Same-cycle clear and capture/frame event: clear wins for counters and flags. DIGITS/RAW still update.

## Timing
- Every output resets to 0: ack, dat_o, irq_o, all registers. The filter resets disarmed and the counter resets to 0.
- Capture latency: a pattern stable at the pins from cycle 0 updates its registers at the edge ending cycle 2+STABLE_CYCLES-1. It is readable from cycle 2+STABLE_CYCLES.
- irq_o is high exactly one cycle, coincident with the frame_cnt update.
- Wishbone handling:
  - ack rises the cycle after cyc&stb with an in-window address and no ack currently high, and holds one cycle. dat_o is valid only while ack is high, otherwise 0.
  - Back-to-back transfers take 2 cycles each.
  - Out-of-window accesses get no ack.
  - The CTRL write takes effect at the ack edge.
- A reset mid-transfer drops ack the next cycle. A reset mid-stability-window discards the pending capture.

## Structure
- Package seven_seg_pkg: register offsets, STATUS/DIGITS bit positions, the 16 glyph constants.
- Sub-module seven_seg_decode: 7-bit pattern → {valid, hex[3:0]}. Shared with the display driver's self-check.

## Test plan
- Present en=0001, seg=0x3F for 10 cycles with STABLE_CYCLES=4 → DIGITS[3:0]=0, valid[0]=1 from cycle 6; a read returns 0x0001_0000.
- Scan 0x06,0x5B,0x4F,0x66 on digits 0..3 with 8 cycles each → DIGITS=0x000F_4321, frame_cnt=1, one irq_o pulse with irq_en=1.
- A 3-cycle glitch en=0010 between stable digits → no capture, EXP unchanged.
- en=0011 held stable → onehot_err=1, DIGITS unchanged; a CTRL write 0x2 → STATUS=0.
- Sequence d0,d2 → seq_err=1. Then d0..d3 → frame_cnt increments. With CNT_W=4, after 16 frames → 0.
- Read at 0x3000_0010 → no ack for 8 cycles. Reset asserted during the ack cycle → ack low next cycle, all registers 0.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg
// Shared definitions for the 7-segment display capture block and its decoder.
// Contents:
//   - Wishbone register offsets (word index taken from adr[3:2])
//   - DIGITS / STATUS / CTRL bit positions
//   - the 16 hex glyph patterns (segments g..a, bit 0 = segment a)
//   - the frame sequencer expected-digit enum
package seven_seg_pkg;

    localparam logic [1:0] REG_DIGITS = 2'd0;
    localparam logic [1:0] REG_RAW    = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int DIGITS_VALID_LSB  = 16;
    localparam int DIGITS_DP_LSB     = 20;

    localparam int STATUS_SEQ_ERR    = 16;
    localparam int STATUS_ONEHOT_ERR = 17;
    localparam int STATUS_FRAME_DONE = 18;

    localparam int CTRL_IRQ_EN       = 0;
    localparam int CTRL_CLEAR        = 1;

    // Index i holds the glyph for hex digit i; b and d are the lowercase forms
    // so that every glyph is distinct from the digits 6, 8 and 0.
    localparam logic [15:0][6:0] GLYPHS = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic [1:0] {
        EXP_D0 = 2'd0,
        EXP_D1 = 2'd1,
        EXP_D2 = 2'd2,
        EXP_D3 = 2'd3
    } exp_digit_e;

endpackage

// File: rtl/seven_seg_capture_if.sv
// seven_seg_capture_if
// Wishbone classic slave bus used to read back the captured display image.
// Signals: cyc/stb/we strobes, 4-bit byte selects, 32-bit byte address,
// 32-bit write data, single-cycle ack and 32-bit read data.
// Modports: master (SoC side) drives the request, slave (capture block) answers.
interface seven_seg_capture_if;

    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/seven_seg_decode.sv
// seven_seg_decode
// Combinational 7-segment pattern to hex decoder, also used by the display
// driver's self-check.
// Ports:
//   i_seg   [6:0] segment pattern, bit 0 = segment a, bit 6 = segment g
//   o_valid       pattern is one of the 16 hex glyphs
//   o_hex   [3:0] decoded digit, 0 when the pattern is not a glyph
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic       o_valid,
    output logic [3:0] o_hex
);

    // Search the glyph table; glyphs are unique so at most one entry matches.
    always_comb begin
        o_valid = 1'b0;
        o_hex   = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (i_seg == GLYPHS[i]) begin
                o_valid = 1'b1;
                o_hex   = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seven_seg_capture.sv
// seven_seg_capture
// Samples the multiplexed 4-digit 7-segment bus, filters scan transitions,
// rebuilds the display image and exposes it over a Wishbone slave.
// Ports:
//   wb_clk_i, wb_rst_i  clock and synchronous active-high reset
//   wb                  Wishbone slave (DIGITS, RAW, STATUS, CTRL registers)
//   digit_en_i [3:0]    digit enables, one-hot while a digit is shown
//   seg_i      [7:0]    segments a..g in [6:0], decimal point in [7]
//   irq_o               one-cycle pulse when a full d0..d3 frame completes
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter logic [31:0] BASE_ADR      = 32'h3000_0000,
    parameter int          STABLE_CYCLES = 4,
    parameter int          CNT_W         = 16
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    seven_seg_capture_if.slave wb,
    input  logic [3:0]         digit_en_i,
    input  logic [7:0]         seg_i,
    output logic               irq_o
);

    localparam int STAB_W = $clog2(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_FIRE = STAB_W'(STABLE_CYCLES - 2);
    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CYCLES - 1);

    logic [11:0]       r_sync1, r_sync2, r_prev;
    logic [STAB_W-1:0] r_stab;
    logic              r_armed;
    logic [3:0]        w_en;
    logic [7:0]        w_seg;
    logic              w_same, w_capture, w_onehot, w_capDigit, w_capErr;
    logic [1:0]        w_k;
    logic              w_decValid;
    logic [3:0]        w_decHex;
    logic [3:0][7:0]   r_raw;
    logic [3:0][3:0]   r_hex;
    logic [3:0]        r_valid, r_dp;
    exp_digit_e        r_exp;
    logic [CNT_W-1:0]  r_frameCnt;
    logic              r_seqErr, r_onehotErr, r_frameDone, r_irq, r_irqEn;
    logic              w_inWindow, w_req, w_ctrlWr, w_clear;
    logic [31:0]       w_status, w_rdata;
    logic              r_ack;
    logic [31:0]       r_dat;
    logic              w_unused;

    assign w_en       = r_sync2[11:8];
    assign w_seg      = r_sync2[7:0];
    assign w_same     = (r_sync2 == r_prev);
    // The counter holds the number of repeats already seen, so the capture
    // fires on the edge where it would step to STABLE_CYCLES-1.
    assign w_capture  = r_armed && w_same && (r_stab == STAB_FIRE);
    assign w_onehot   = (w_en != 4'd0) && ((w_en & (w_en - 4'd1)) == 4'd0);
    assign w_capDigit = w_capture && w_onehot;
    assign w_capErr   = w_capture && (w_en != 4'd0) && !w_onehot;

    assign w_inWindow = (wb.wbs_adr_i[31:4] == BASE_ADR[31:4]);
    assign w_req      = wb.wbs_cyc_i && wb.wbs_stb_i && w_inWindow && !r_ack;
    assign w_ctrlWr   = w_req && wb.wbs_we_i && (wb.wbs_adr_i[3:2] == REG_CTRL) && wb.wbs_sel_i[0];
    assign w_clear    = w_ctrlWr && wb.wbs_dat_i[CTRL_CLEAR];

    assign wb.wbs_ack_o = r_ack;
    assign wb.wbs_dat_o = r_dat;
    assign irq_o        = r_irq;
    assign w_unused     = ^{wb.wbs_adr_i[1:0], wb.wbs_sel_i[3:1], wb.wbs_dat_i[31:2]};

    // Turn the one-hot digit enable into a digit index.
    always_comb begin
        w_k = 2'd0;
        case (w_en)
            4'b0010: w_k = 2'd1;
            4'b0100: w_k = 2'd2;
            4'b1000: w_k = 2'd3;
            default: w_k = 2'd0;
        endcase
    end

    seven_seg_decode u_decode (
        .i_seg   (w_seg[6:0]),
        .o_valid (w_decValid),
        .o_hex   (w_decHex)
    );

    // Two-flop synchronizer followed by the stability filter. Any change in
    // the sampled enable/segment word restarts the count and re-arms, so each
    // stable dwell of a scan slot yields exactly one capture.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_stab  <= '0;
            r_armed <= 1'b0;
        end else begin
            r_sync1 <= {digit_en_i, seg_i};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (!w_same) begin
                r_stab  <= '0;
                r_armed <= 1'b1;
            end else if (r_stab != STAB_MAX) begin
                r_stab <= r_stab + STAB_W'(1);
                if (w_capture) begin
                    r_armed <= 1'b0;
                end
            end
        end
    end

    // Display image: a one-hot capture overwrites that digit's slot. A CTRL
    // clear does not touch the image, only counters and flags.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_raw   <= '0;
            r_hex   <= '0;
            r_valid <= '0;
            r_dp    <= '0;
        end else if (w_capDigit) begin
            r_raw[w_k]   <= w_seg;
            r_dp[w_k]    <= w_seg[7];
            r_valid[w_k] <= w_decValid;
            r_hex[w_k]   <= w_decHex;
        end
    end

    // Frame sequencer and sticky flags. Digits must arrive in 0,1,2,3 order;
    // an out-of-order digit flags an error and resynchronises, treating a
    // stray digit 0 as the start of a new frame. A clear in the same cycle
    // beats any event, including the frame interrupt.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_exp       <= EXP_D0;
            r_frameCnt  <= '0;
            r_seqErr    <= 1'b0;
            r_onehotErr <= 1'b0;
            r_frameDone <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_irq <= 1'b0;
            if (w_clear) begin
                r_exp       <= EXP_D0;
                r_frameCnt  <= '0;
                r_seqErr    <= 1'b0;
                r_onehotErr <= 1'b0;
                r_frameDone <= 1'b0;
            end else begin
                if (w_capErr) begin
                    r_onehotErr <= 1'b1;
                end
                if (w_capDigit) begin
                    if (w_k == r_exp) begin
                        if (r_exp == EXP_D3) begin
                            r_frameCnt  <= r_frameCnt + CNT_W'(1);
                            r_frameDone <= 1'b1;
                            r_irq       <= r_irqEn;
                            r_exp       <= EXP_D0;
                        end else begin
                            r_exp <= exp_digit_e'(w_k + 2'd1);
                        end
                    end else begin
                        r_seqErr <= 1'b1;
                        r_exp    <= (w_k == 2'd0) ? EXP_D1 : EXP_D0;
                    end
                end
            end
        end
    end

    // Register read multiplexer; unused bits stay zero.
    always_comb begin
        w_status = '0;
        w_status[CNT_W-1:0]        = r_frameCnt;
        w_status[STATUS_SEQ_ERR]    = r_seqErr;
        w_status[STATUS_ONEHOT_ERR] = r_onehotErr;
        w_status[STATUS_FRAME_DONE] = r_frameDone;
        w_rdata = '0;
        case (wb.wbs_adr_i[3:2])
            REG_DIGITS: w_rdata = {8'h00, r_dp, r_valid, r_hex};
            REG_RAW:    w_rdata = r_raw;
            REG_STATUS: w_rdata = w_status;
            REG_CTRL:   w_rdata = {31'd0, r_irqEn};
            default:    w_rdata = '0;
        endcase
    end

    // Wishbone slave: one-cycle ack after an in-window request, read data
    // presented only alongside ack. Blocking re-requests while ack is high
    // makes back-to-back transfers take two cycles each.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack   <= 1'b0;
            r_dat   <= '0;
            r_irqEn <= 1'b0;
        end else begin
            r_ack <= w_req;
            r_dat <= w_req ? w_rdata : 32'd0;
            if (w_ctrlWr) begin
                r_irqEn <= wb.wbs_dat_i[CTRL_IRQ_EN];
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture
// Self-checking bench for seven_seg_capture. Stimulus tasks drive the display
// pins and Wishbone requests, pushing each expected read value into a queue;
// a monitor pops and compares whenever ack is seen. Expected values come from
// a behavioural model of the display image, sequencer and flags.
`timescale 1ns/1ps
module tb_seven_seg_capture;

    localparam int          STABLE   = 4;
    localparam int          CNTW     = 4;
    localparam logic [31:0] BASE     = 32'h3000_0000;
    localparam logic [31:0] A_DIGITS = BASE + 32'h0;
    localparam logic [31:0] A_RAW    = BASE + 32'h4;
    localparam logic [31:0] A_STATUS = BASE + 32'h8;
    localparam logic [31:0] A_CTRL   = BASE + 32'hC;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] digitEn = 4'd0;
    logic [7:0] seg = 8'd0;
    logic       irq;

    seven_seg_capture_if bus ();

    seven_seg_capture #(
        .BASE_ADR      (BASE),
        .STABLE_CYCLES (STABLE),
        .CNT_W         (CNTW)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wb         (bus),
        .digit_en_i (digitEn),
        .seg_i      (seg),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails = 0;
    int irqSeen = 0;

    bit          qIsRead[$];
    logic [31:0] qData[$];
    string       qName[$];

    int   glyph[16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                        'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};
    int   mRaw[4], mHex[4], mValid[4], mDp[4];
    int   mExp, mFrames, mIrqCount;
    bit   mSeqErr, mOneHotErr, mFrameDone, mIrqEn;
    logic [11:0] lastPat;
    int   runLen;

    // One comparison: count it, and report a mismatch with both values.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic void modelClear();
        mExp = 0; mFrames = 0; mSeqErr = 0; mOneHotErr = 0; mFrameDone = 0;
    endfunction

    function automatic void modelReset();
        modelClear();
        mIrqEn = 0;
        for (int i = 0; i < 4; i++) begin
            mRaw[i] = 0; mHex[i] = 0; mValid[i] = 0; mDp[i] = 0;
        end
    endfunction

    // What a single accepted capture of (en, s) does to the display state.
    function automatic void modelCapture(input logic [3:0] en, input logic [7:0] s);
        int k;
        if (en == 4'd0) return;
        if ($countones(en) != 1) begin
            mOneHotErr = 1;
            return;
        end
        k = 0;
        for (int i = 0; i < 4; i++) if (en[i]) k = i;
        mRaw[k] = s; mDp[k] = s[7]; mValid[k] = 0; mHex[k] = 0;
        for (int g = 0; g < 16; g++) begin
            if (glyph[g] == int'(s[6:0])) begin
                mValid[k] = 1; mHex[k] = g;
            end
        end
        if (k == mExp) begin
            if (mExp == 3) begin
                mFrames = (mFrames + 1) % (1 << CNTW);
                mFrameDone = 1;
                if (mIrqEn) mIrqCount++;
                mExp = 0;
            end else begin
                mExp++;
            end
        end else begin
            mSeqErr = 1;
            mExp = (k == 0) ? 1 : 0;
        end
    endfunction

    function automatic logic [31:0] expDigits();
        logic [31:0] v = 0;
        for (int k = 0; k < 4; k++) begin
            v = v | (32'(mHex[k]) << (4 * k)) | (32'(mValid[k]) << (16 + k)) | (32'(mDp[k]) << (20 + k));
        end
        return v;
    endfunction

    function automatic logic [31:0] expRaw();
        logic [31:0] v = 0;
        for (int k = 0; k < 4; k++) v = v | (32'(mRaw[k]) << (8 * k));
        return v;
    endfunction

    function automatic logic [31:0] expStatus();
        return 32'(mFrames) | (32'(mSeqErr) << 16) | (32'(mOneHotErr) << 17) | (32'(mFrameDone) << 18);
    endfunction

    // A pattern is captured once it has been held for STABLE consecutive
    // cycles since it last changed.
    task automatic applyStimulus(input logic [3:0] en, input logic [7:0] s, input int hold);
        logic [11:0] pat;
        pat = {en, s};
        digitEn = en;
        seg = s;
        repeat (hold) @(negedge clk);
        if (pat == lastPat) runLen += hold;
        else runLen = hold;
        if (runLen >= STABLE && runLen - hold < STABLE) modelCapture(en, s);
        lastPat = pat;
    endtask

    // Issue one Wishbone transfer; the expected read value goes to the queue.
    task automatic busCycle(input logic [31:0] adr, input bit we, input logic [31:0] data,
                            input logic [3:0] sel, input string name, input logic [31:0] expData,
                            input bit resetOnAck);
        int waitCnt;
        qIsRead.push_back(!we);
        qData.push_back(expData);
        qName.push_back(name);
        bus.wbs_adr_i = adr; bus.wbs_we_i = we; bus.wbs_dat_i = data; bus.wbs_sel_i = sel;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
        waitCnt = 0;
        do begin
            @(negedge clk);
            waitCnt++;
        end while (bus.wbs_ack_o !== 1'b1 && waitCnt < 16);
        if (resetOnAck) rst = 1'b1;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        if (bus.wbs_ack_o !== 1'b1) begin
            checks++;
            fails++;
            $display("[TB] FAIL ackTimeout %s: no ack within 16 cycles", name);
            void'(qIsRead.pop_back()); void'(qData.pop_back()); void'(qName.pop_back());
        end
    endtask

    task automatic wbRead(input logic [31:0] adr, input string name, input logic [31:0] expData);
        busCycle(adr, 1'b0, 32'd0, 4'd0, name, expData, 1'b0);
    endtask

    task automatic wbWrite(input logic [31:0] adr, input logic [31:0] data, input logic [3:0] sel);
        busCycle(adr, 1'b1, data, sel, "write", 32'd0, 1'b0);
        if (adr == A_CTRL && sel[0]) begin
            mIrqEn = data[0];
            if (data[1]) modelClear();
        end
    endtask

    task automatic readAll(input string tag);
        wbRead(A_DIGITS, {tag, ".digits"}, expDigits());
        wbRead(A_RAW,    {tag, ".raw"},    expRaw());
        wbRead(A_STATUS, {tag, ".status"}, expStatus());
        wbRead(A_CTRL,   {tag, ".ctrl"},   32'(mIrqEn));
        checkOutput({tag, ".irqCount"}, irqSeen, mIrqCount);
    endtask

    // Monitor: counts irq cycles and checks every acked read against the queue.
    always @(negedge clk) begin
        if (irq === 1'b1) irqSeen++;
        if (bus.wbs_ack_o === 1'b1) begin
            if (qData.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpectedAck: got ack with dat 0x%08h, expected no ack", bus.wbs_dat_o);
            end else begin
                bit          isRd;
                logic [31:0] expV;
                string       nm;
                isRd = qIsRead.pop_front();
                expV = qData.pop_front();
                nm   = qName.pop_front();
                if (isRd) checkOutput(nm, bus.wbs_dat_o, expV);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ackCount;
        int r;
        logic [3:0] en;
        logic [7:0] s;

        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'd0; bus.wbs_adr_i = 32'd0; bus.wbs_dat_i = 32'd0;
        mIrqCount = 0;
        modelReset();
        lastPat = 12'd0;
        runLen = 1000;

        $display("[TB] reset");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("resetAck", 32'(bus.wbs_ack_o), 32'd0);
        checkOutput("resetDat", bus.wbs_dat_o, 32'd0);
        checkOutput("resetIrq", 32'(irq), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        readAll("afterReset");

        $display("[TB] capture latency");
        digitEn = 4'b0001;
        seg = 8'h3F;
        repeat (5) @(negedge clk);
        wbRead(A_DIGITS, "latencyBefore", expDigits());
        modelCapture(4'b0001, 8'h3F);
        wbRead(A_DIGITS, "latencyAfter", expDigits());
        wbRead(A_RAW, "latencyRaw", expRaw());
        repeat (4) @(negedge clk);
        lastPat = {4'b0001, 8'h3F};
        runLen = 100;

        $display("[TB] full frame scan");
        wbWrite(A_CTRL, 32'h1, 4'hF);
        wbWrite(A_CTRL, 32'h3, 4'h1);
        wbRead(A_STATUS, "clearedStatus", expStatus());
        applyStimulus(4'b0001, 8'h06, 8);
        applyStimulus(4'b0010, 8'h5B, 8);
        applyStimulus(4'b0100, 8'h4F, 8);
        applyStimulus(4'b1000, 8'h66, 8);
        readAll("frame1");

        $display("[TB] glitch rejection");
        applyStimulus(4'b0001, 8'hBF, 8);
        applyStimulus(4'b0010, 8'h06, 3);
        applyStimulus(4'b0010, 8'h5B, 8);
        wbRead(A_STATUS, "glitchStatus", expStatus());
        applyStimulus(4'b0100, 8'h4F, 8);
        applyStimulus(4'b1000, 8'hE6, 8);
        readAll("frame2");

        $display("[TB] non-one-hot enables");
        applyStimulus(4'b0011, 8'h06, 8);
        wbRead(A_STATUS, "onehotStatus", expStatus());
        wbRead(A_DIGITS, "onehotDigits", expDigits());
        wbWrite(A_CTRL, 32'h2, 4'h1);
        readAll("afterClear");

        $display("[TB] sequence error");
        applyStimulus(4'b0001, 8'h3F, 8);
        applyStimulus(4'b0100, 8'h5B, 8);
        wbRead(A_STATUS, "seqErrStatus", expStatus());
        applyStimulus(4'b0001, 8'h77, 8);
        applyStimulus(4'b0010, 8'h7C, 8);
        applyStimulus(4'b0100, 8'h39, 8);
        applyStimulus(4'b1000, 8'h5E, 8);
        readAll("seqRecover");

        $display("[TB] frame counter wrap");
        wbWrite(A_CTRL, 32'h3, 4'h1);
        for (int f = 0; f < 16; f++) begin
            for (int k = 0; k < 4; k++) begin
                applyStimulus(4'(1 << k), 8'(glyph[(f + k) % 16]), 6);
            end
        end
        readAll("wrap");

        $display("[TB] random scan");
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0) en = 4'd0;
            else if (r == 1) begin
                en = 4'(1 << $urandom_range(0, 3)) | 4'(1 << $urandom_range(0, 3));
                if ($countones(en) < 2) en = 4'b1010;
            end else if (r < 6) en = 4'(1 << mExp);
            else en = 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 9) < 7) s = 8'(glyph[$urandom_range(0, 15)]) | 8'($urandom_range(0, 1) << 7);
            else s = 8'($urandom_range(0, 255));
            applyStimulus(en, s, $urandom_range(2, 9));
            if (it % 10 == 9) begin
                applyStimulus(4'd0, 8'd0, 8);
                readAll("random");
            end
        end

        $display("[TB] out-of-window access");
        applyStimulus(4'd0, 8'd0, 8);
        bus.wbs_adr_i = BASE + 32'h10; bus.wbs_we_i = 1'b0; bus.wbs_sel_i = 4'hF;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
        ackCount = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.wbs_ack_o === 1'b1) ackCount++;
        end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        checkOutput("noAckOutOfWindow", ackCount, 32'd0);

        $display("[TB] reset during ack");
        busCycle(A_STATUS, 1'b0, 32'd0, 4'd0, "midResetRead", expStatus(), 1'b1);
        @(negedge clk);
        checkOutput("ackDropOnReset", 32'(bus.wbs_ack_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        lastPat = 12'd0;
        runLen = 1000;
        @(negedge clk);
        readAll("afterMidReset");
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
